instr_fetch_seq: RTL and testbench

//  Per-sample program sequencer: on each sample tick, walks the block instruction memory

---
 rtl/instr_fetch_seq.sv | 210 +++++++++++++++++++++
 tb/tb_instr_fetch_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// Per-sample program sequencer. On an accepted sample tick it walks the
// instruction RAM from PC 0 to len-1 and streams words to the decoder.
// Reads are credit-limited so every word fits in a 2-entry skid buffer.
//
// Handshake: a word moves on a rising edge iff instr_valid & out_ready were
// both high in the preceding cycle. instr_valid comes from flops only and
// never depends on out_ready. While instr_valid is high and out_ready is low,
// instr and instr_pc stay stable.
module instr_fetch_seq #(
  parameter int N_BLOCKS    = 64,
  parameter int PC_WIDTH    = $clog2(N_BLOCKS),
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sample_tick,
  input  logic [PC_WIDTH:0]      n_blocks,
  input  logic                   instr_wr_en,
  input  logic [PC_WIDTH-1:0]    instr_wr_addr,
  input  logic [INSTR_WIDTH-1:0] instr_wr_data,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   prog_busy,
  output logic                   prog_done,
  output logic                   overrun
);

  localparam int LW = PC_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    rd_pc_q, rd_pc_d;
  logic [PC_WIDTH-1:0]    last_pc_q, last_pc_d;
  logic                   rd_vld_q, rd_vld_d;
  logic [PC_WIDTH-1:0]    rd_pipe_pc_q, rd_pipe_pc_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic [PC_WIDTH-1:0]    e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;

  logic [INSTR_WIDTH-1:0] mem [N_BLOCKS];
  logic [INSTR_WIDTH-1:0] ram_rdata;
  logic                   rd_en;
  logic                   pop;
  logic                   push;
  logic [2:0]             occ;
  logic [LW-1:0]          len_in;
  logic [LW-1:0]          len_m1;

  // Program length is clamped to the RAM depth; PC never wraps.
  assign len_in = (n_blocks > LW'(N_BLOCKS)) ? LW'(N_BLOCKS) : n_blocks;
  assign len_m1 = len_in - LW'(1);

  assign pop  = (cnt_q != 2'd0) && out_ready;
  assign push = rd_vld_q;
  // Words the buffer will hold after this edge if no further pop occurs;
  // a read issued now lands one edge later, so it needs occ <= 1.
  assign occ  = 3'(cnt_q) - 3'(pop) + 3'(rd_vld_q);

  // Sequencer, read credit and skid buffer next-state logic.
  always_comb begin
    state_d      = state_q;
    rd_pc_d      = rd_pc_q;
    last_pc_d    = last_pc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = 1'b0;
    rd_en        = 1'b0;
    rd_vld_d     = 1'b0;
    rd_pipe_pc_d = rd_pipe_pc_q;
    cnt_d        = cnt_q;
    e0_data_d    = e0_data_q;
    e0_pc_d      = e0_pc_q;
    e1_data_d    = e1_data_q;
    e1_pc_d      = e1_pc_q;

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          if (done_q) begin
            overrun_d = 1'b1;
          end else if (len_in == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = S_RUN;
            busy_d    = 1'b1;
            rd_pc_d   = '0;
            last_pc_d = len_m1[PC_WIDTH-1:0];
          end
        end
      end
      S_RUN: begin
        overrun_d = sample_tick;
        if (occ <= 3'd1) begin
          rd_en = 1'b1;
          if (rd_pc_q == last_pc_q) begin
            state_d = S_DRAIN;
          end else begin
            rd_pc_d = rd_pc_q + PC_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        overrun_d = sample_tick;
        if (pop && (cnt_q == 2'd1) && !rd_vld_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_en) begin
      rd_vld_d     = 1'b1;
      rd_pipe_pc_d = rd_pc_q;
    end

    // Entry 0 is always the presented word; entry 1 absorbs stalls.
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          e0_data_d = ram_rdata;
          e0_pc_d   = rd_pipe_pc_q;
        end else begin
          e1_data_d = ram_rdata;
          e1_pc_d   = rd_pipe_pc_q;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_data_d = e1_data_q;
        e0_pc_d   = e1_pc_q;
        cnt_d     = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_data_d = ram_rdata;
          e0_pc_d   = rd_pipe_pc_q;
        end else begin
          e0_data_d = e1_data_q;
          e0_pc_d   = e1_pc_q;
          e1_data_d = ram_rdata;
          e1_pc_d   = rd_pipe_pc_q;
        end
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any program in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rd_pc_q      <= '0;
      last_pc_q    <= '0;
      rd_vld_q     <= 1'b0;
      rd_pipe_pc_q <= '0;
      cnt_q        <= 2'd0;
      e0_data_q    <= '0;
      e0_pc_q      <= '0;
      e1_data_q    <= '0;
      e1_pc_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_pc_q      <= rd_pc_d;
      last_pc_q    <= last_pc_d;
      rd_vld_q     <= rd_vld_d;
      rd_pipe_pc_q <= rd_pipe_pc_d;
      cnt_q        <= cnt_d;
      e0_data_q    <= e0_data_d;
      e0_pc_q      <= e0_pc_d;
      e1_data_q    <= e1_data_d;
      e1_pc_q      <= e1_pc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Instruction RAM: host write port plus synchronous read (read-before-write).
  always_ff @(posedge clk) begin
    if (instr_wr_en) begin
      mem[instr_wr_addr] <= instr_wr_data;
    end
    if (rd_en) begin
      ram_rdata <= mem[rd_pc_q];
    end
  end

  assign instr       = e0_data_q;
  assign instr_pc    = e0_pc_q;
  assign instr_valid = (cnt_q != 2'd0);
  assign prog_busy   = busy_q;
  assign prog_done   = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: timing of the first word, stalls,
// empty and over-length programs, overrun, mid-stream reset, host writes.
module tb_instr_fetch_seq;

  logic        clk;
  logic        reset_n;
  logic        sample_tick;
  logic [6:0]  n_blocks;
  logic        instr_wr_en;
  logic [5:0]  instr_wr_addr;
  logic [31:0] instr_wr_data;
  logic        out_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  instr_pc;
  logic        prog_busy;
  logic        prog_done;
  logic        overrun;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_mem [64];

  instr_fetch_seq #(.N_BLOCKS(64), .PC_WIDTH(6), .INSTR_WIDTH(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_tick   (sample_tick),
    .n_blocks      (n_blocks),
    .instr_wr_en   (instr_wr_en),
    .instr_wr_addr (instr_wr_addr),
    .instr_wr_data (instr_wr_data),
    .out_ready     (out_ready),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .prog_busy     (prog_busy),
    .prog_done     (prog_done),
    .overrun       (overrun)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int addr, input logic [31:0] data);
    instr_wr_en   = 1'b1;
    instr_wr_addr = 6'(addr);
    instr_wr_data = data;
    exp_mem[addr] = data;
    step();
    instr_wr_en   = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_instr"}, 64'(instr), 64'd0);
    chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_pc"}, 64'(instr_pc), 64'd0);
    chk({tag, "_busy"}, 64'(prog_busy), 64'd0);
    chk({tag, "_done"}, 64'(prog_done), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  // Issue one tick with the given length; returns right after the edge that samples it.
  task automatic fire_tick(input int len);
    n_blocks    = 7'(len);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // Follows a running program from the post-tick edge, collecting handshakes.
  task automatic run_stream(input string name, input int exp_len, input int stall_lo,
                            input int stall_hi, input int tick_at, input int exp_ovr,
                            input int budget);
    int          idx = 0;
    int          dones = 0;
    int          ovrs = 0;
    int          c = 0;
    int          done_c = 0;
    logic        prev_stall = 1'b0;
    logic [5:0]  prev_pc = '0;
    logic [31:0] prev_instr = '0;
    while (c < budget && !(dones > 0 && c > done_c + 3)) begin
      out_ready   = !(c >= stall_lo && c <= stall_hi);
      sample_tick = (c == tick_at);
      if (overrun) ovrs++;
      if (prog_done) begin
        dones++;
        done_c = c;
      end
      if (prev_stall) begin
        chk({name, "_hold_valid"}, 64'(instr_valid), 64'd1);
        chk({name, "_hold_pc"}, 64'(instr_pc), 64'(prev_pc));
        chk({name, "_hold_instr"}, 64'(instr), 64'(prev_instr));
      end
      if (instr_valid && out_ready) begin
        chk({name, "_pc"}, 64'(instr_pc), 64'(idx & 63));
        chk({name, "_instr"}, 64'(instr), 64'(exp_mem[idx & 63]));
        idx++;
      end
      prev_stall = instr_valid && !out_ready;
      prev_pc    = instr_pc;
      prev_instr = instr;
      step();
      c++;
    end
    sample_tick = 1'b0;
    out_ready   = 1'b1;
    chk({name, "_word_count"}, 64'(idx), 64'(exp_len));
    chk({name, "_done_count"}, 64'(dones), 64'd1);
    chk({name, "_overrun_count"}, 64'(ovrs), 64'(exp_ovr));
    chk({name, "_busy_after"}, 64'(prog_busy), 64'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    sample_tick   = 1'b0;
    n_blocks      = '0;
    instr_wr_en   = 1'b0;
    instr_wr_addr = '0;
    instr_wr_data = '0;
    out_ready     = 1'b1;

    // Reset state
    #1;
    chk_outputs_zero("reset");
    step();
    step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 64; i++) begin
      host_write(i, 32'hA000_0000 + 32'(i));
    end
    step();
    chk_outputs_zero("idle_after_load");

    // Test 1: eight words, exact latency, done one cycle after last handshake
    fire_tick(8);
    chk("t1_busy_e0", 64'(prog_busy), 64'd1);
    chk("t1_valid_e0", 64'(instr_valid), 64'd0);
    step();
    chk("t1_valid_e1", 64'(instr_valid), 64'd0);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", 64'(instr_valid), 64'd1);
      chk("t1_pc", 64'(instr_pc), 64'(k));
      chk("t1_instr", 64'(instr), 64'(32'hA000_0000 + 32'(k)));
      chk("t1_done_early", 64'(prog_done), 64'd0);
      step();
    end
    chk("t1_done", 64'(prog_done), 64'd1);
    chk("t1_busy_fall", 64'(prog_busy), 64'd0);
    chk("t1_valid_end", 64'(instr_valid), 64'd0);
    step();
    chk("t1_done_pulse", 64'(prog_done), 64'd0);
    step();

    // Test 2: stall for three stream cycles
    fire_tick(8);
    run_stream("t2", 8, 5, 7, -1, 0, 40);
    step();

    // Test 3: empty program
    fire_tick(0);
    chk("t3_done", 64'(prog_done), 64'd1);
    chk("t3_busy", 64'(prog_busy), 64'd0);
    chk("t3_valid", 64'(instr_valid), 64'd0);
    step();
    chk("t3_done_pulse", 64'(prog_done), 64'd0);
    chk("t3_busy2", 64'(prog_busy), 64'd0);
    chk("t3_valid2", 64'(instr_valid), 64'd0);
    step();

    // Test 4: request longer than the RAM clamps to 64 words
    fire_tick(100);
    run_stream("t4", 64, -1, -1, -1, 0, 120);
    step();

    // Test 5: second tick mid-program is dropped with an overrun pulse
    fire_tick(8);
    run_stream("t5", 8, -1, -1, 3, 1, 40);
    step();

    // Tick in the same cycle as the done pulse of an empty program
    fire_tick(0);
    chk("t5b_done", 64'(prog_done), 64'd1);
    n_blocks    = 7'd8;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("t5b_overrun", 64'(overrun), 64'd1);
    chk("t5b_busy", 64'(prog_busy), 64'd0);
    step();
    chk("t5b_overrun_pulse", 64'(overrun), 64'd0);
    step();

    // Test 6: reset while pc 4 is presented
    fire_tick(8);
    step();
    step();
    step();
    step();
    step();
    step();
    chk("t6_pc_before", 64'(instr_pc), 64'd4);
    chk("t6_valid_before", 64'(instr_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("t6_async");
    step();
    reset_n = 1'b1;
    step();
    chk_outputs_zero("t6_released");

    // Host write after reset lands in the next program
    host_write(2, 32'h1234_5678);
    step();
    fire_tick(8);
    run_stream("t6_restart", 8, -1, -1, -1, 0, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
